prog_host_loader: RTL

- Host-side sequencer for the 8-bit custom core; it drives the other end of the core's start/done handshake.
- Loads an input byte image into data memory while holding the core in start.
- Releases start, waits for done (with a timeout), then streams a result region of data memory out to the host.
- Sits beside the core top level and owns the data-memory port whenever the core is not running.

---
 rtl/prog_host_loader_pkg.sv | 19 +
 rtl/prog_host_loader_skid.sv | 26 ++
 rtl/prog_host_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prog_host_loader_pkg.sv
// Shared types and default parameter values for the host-side program loader.
package prog_host_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HOLD  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int DEF_AW        = 8;
  localparam int DEF_LOAD_BASE = 0;
  localparam int DEF_LOAD_LEN  = 64;
  localparam int DEF_RES_BASE  = 64;
  localparam int DEF_RES_LEN   = 32;
  localparam int DEF_TIMEOUT   = 4096;

endpackage

// File: rtl/prog_host_loader_skid.sv
// One-entry registered output stage: captures a memory byte and holds it
// (valid and data stable) until the host takes it with out_ready.
module host_out_skid (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       ready,
  input  logic [7:0] din,
  output logic       valid,
  output logic [7:0] data
);

  // load is only asserted by the owner while the entry is empty
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= 8'h00;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/prog_host_loader.sv
// Host-side sequencer: loads an image into data memory with the core held in
// start, releases it, waits for done (bounded), then streams a result region out.
//
// Handshakes: a byte moves on in_valid/in_ready (load) or out_valid/out_ready
// (drain) only on a cycle where both are 1; once out_valid is raised, out_data
// and out_valid hold until the host accepts.
module prog_host_loader
  import prog_host_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int LOAD_BASE = DEF_LOAD_BASE,
  parameter int LOAD_LEN  = DEF_LOAD_LEN,
  parameter int RES_BASE  = DEF_RES_BASE,
  parameter int RES_LEN   = DEF_RES_LEN,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          core_start,
  input  logic          core_done,
  output logic          host_owns_mem,
  output logic [AW-1:0] dm_addr,
  output logic          dm_wr_en,
  output logic [7:0]    dm_dat_in,
  input  logic [7:0]    dm_dat_out,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          timeout_err,
  output state_t        state_dbg
);

  localparam int IW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] LOAD_LAST   = IW'(LOAD_LEN - 1);
  localparam logic [IW-1:0] RES_LAST    = IW'(RES_LEN - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_SAT      = CW'(TIMEOUT);
  localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RES_BASE_A  = AW'(RES_BASE);

  state_t        state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic [CW-1:0] run_cnt, run_cnt_next;
  logic          timeout_next;
  logic          skid_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      run_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      run_cnt     <= run_cnt_next;
      timeout_err <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    run_cnt_next  = run_cnt;
    timeout_next  = timeout_err;
    core_start    = 1'b0;
    in_ready      = 1'b0;
    host_owns_mem = 1'b1;
    dm_addr       = '0;
    dm_wr_en      = 1'b0;
    dm_dat_in     = 8'h00;
    skid_load     = 1'b0;
    busy          = (state != IDLE);

    case (state)
      IDLE: begin
        if (go) begin
          state_next   = LOAD;
          idx_next     = '0;
          timeout_next = 1'b0;
        end
      end

      LOAD: begin
        core_start = 1'b1;
        in_ready   = 1'b1;
        dm_addr    = LOAD_BASE_A + idx[AW-1:0];
        if (in_valid) begin
          dm_wr_en  = 1'b1;
          dm_dat_in = in_data;
          idx_next  = idx + 1'b1;
          if (idx == LOAD_LAST) state_next = HOLD;
        end
      end

      // Keeps start asserted one cycle past the final write.
      HOLD: begin
        core_start   = 1'b1;
        run_cnt_next = '0;
        state_next   = RUN;
      end

      // done on the first RUN cycle can be left over from the previous program.
      RUN: begin
        host_owns_mem = 1'b0;
        run_cnt_next  = (run_cnt == TO_SAT) ? run_cnt : run_cnt + 1'b1;
        if ((run_cnt != '0) && core_done) begin
          state_next = DRAIN;
          idx_next   = '0;
        end else if (run_cnt >= TO_LAST) begin
          timeout_next = 1'b1;
          state_next   = DRAIN;
          idx_next     = '0;
        end
      end

      DRAIN: begin
        dm_addr   = RES_BASE_A + idx[AW-1:0];
        skid_load = !out_valid;
        if (out_valid && out_ready) begin
          idx_next = idx + 1'b1;
          if (idx == RES_LAST) state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  host_out_skid u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .ready (out_ready),
    .din   (dm_dat_out),
    .valid (out_valid),
    .data  (out_data)
  );

  assign state_dbg = state;

endmodule
